// File: rtl/fact_sched_pkg.sv
// fact_sched shared types: FSM states, accelerator register map
// and status bit positions.
package fact_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO,
    POLL,
    RD_RES
  } state_t;

  localparam logic [1:0] FACT_A_N    = 2'd0;
  localparam logic [1:0] FACT_A_GO   = 2'd1;
  localparam logic [1:0] FACT_A_STAT = 2'd2;
  localparam logic [1:0] FACT_A_RES  = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

  localparam int JOB_W = 4;
  localparam int RES_W = 34;

endpackage

// File: rtl/fact_sched_fifo.sv
// fact_sched_fifo: synchronous FIFO with wrap-bit pointers.
// A push on a full FIFO is taken only when a pop happens the same cycle.
module fact_sched_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // pointer advance on accepted push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fact_sched.sv
// fact_sched: queues factorial jobs and drives the accelerator bus.
// Optional POLL watchdog enabled by FACT_SCHED_TIMEOUT_EN.
module fact_sched
  import fact_sched_pkg::*;
#(
  parameter int JOB_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  input  logic [3:0]  job_n,
  output logic        job_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        res_timeout,
  input  logic        res_ready,
  output logic        busy,
  output logic [1:0]  fact_a,
  output logic        fact_we,
  output logic [3:0]  fact_wd,
  input  logic [31:0] fact_rd
);

  state_t           state, state_nx;
  logic [3:0]       n_q, n_nx;
  logic             err_q, err_nx;
  logic             job_pop;
  logic             job_full;
  logic             job_empty;
  logic [JOB_W-1:0] job_head;
  logic             res_push;
  logic             res_full;
  logic             res_empty;
  logic [RES_W-1:0] res_wdata;
  logic [RES_W-1:0] res_head;
  logic             to_hit;

  assign job_ready = ~job_full;
  assign res_valid = ~res_empty;
  assign res_data  = res_head[33:2];
  assign res_err   = res_head[1];
  // bit 0 is only ever pushed as 1 by the watchdog
  assign res_timeout = res_head[0];
  assign busy = (state != IDLE) | ~job_empty;

  fact_sched_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (JOB_DEPTH)
  ) u_job_q (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid & ~job_full),
    .wdata (job_n),
    .pop   (job_pop),
    .rdata (job_head),
    .full  (job_full),
    .empty (job_empty)
  );

  fact_sched_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_q (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .wdata (res_wdata),
    .pop   (res_ready),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

`ifdef FACT_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_nx;

  assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

  // POLL cycle counter, zero outside POLL
  always_comb begin
    cnt_nx = '0;
    if (state == POLL && state_nx == POLL)
      cnt_nx = cnt_q + 1'b1;
  end

  // watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_nx;
  end
`else
  assign to_hit = 1'b0;
`endif

  // state and per-job registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      n_q   <= n_nx;
      err_q <= err_nx;
    end
  end

  // next state, bus drive and queue control
  always_comb begin
    state_nx  = state;
    n_nx      = n_q;
    err_nx    = err_q;
    job_pop   = 1'b0;
    res_push  = 1'b0;
    res_wdata = '0;
    fact_a    = FACT_A_STAT;
    fact_we   = 1'b0;
    fact_wd   = '0;
    unique case (state)
      IDLE: begin
        if (!job_empty && !res_full) begin
          job_pop  = 1'b1;
          n_nx     = job_head;
          state_nx = WR_N;
        end
      end
      WR_N: begin
        fact_a   = FACT_A_N;
        fact_we  = 1'b1;
        fact_wd  = n_q;
        state_nx = WR_GO;
      end
      WR_GO: begin
        fact_a   = FACT_A_GO;
        fact_we  = 1'b1;
        fact_wd  = 4'd1;
        state_nx = POLL;
      end
      POLL: begin
        fact_a = FACT_A_STAT;
        if (fact_rd[STAT_DONE]) begin
          err_nx   = fact_rd[STAT_ERR];
          state_nx = RD_RES;
        end else if (to_hit) begin
          res_push  = 1'b1;
          res_wdata = {32'd0, 1'b1, 1'b1};
          state_nx  = IDLE;
        end
      end
      RD_RES: begin
        fact_a    = FACT_A_RES;
        res_push  = 1'b1;
        res_wdata = {fact_rd, err_q, 1'b0};
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/fact_sched.md
# fact_sched

Job scheduler for the memory-mapped factorial accelerator. Accepts a queue of factorial requests (n, 4 bits) from a requester, sequences each one through the accelerator's register interface (write n, write go, poll status, read result), and returns results in order through a result queue. Sits between a requester (CPU-side peripheral or test harness) and the factorial unit's `a`/`we`/`wd`/`rd` port, replacing direct software polling.

## Interface
- `JOB_DEPTH`, 4, job queue entries (power of two, ≥2)
- `RES_DEPTH`, 4, result queue entries (power of two, ≥2)
- `TIMEOUT`, 64, max POLL cycles before abort (used only with `FACT_SCHED_TIMEOUT_EN`)

- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `job_valid`  in  1  requester offers a job
- `job_n`  in  4  factorial operand
- `job_ready`  out  1  job queue not full
- `res_valid`  out  1  result queue not empty
- `res_data`  out  32  factorial result (head of result queue)
- `res_err`  out  1  accelerator error flag (or timeout) for head result
- `res_timeout`  out  1  head result aborted by timeout
- `res_ready`  in  1  requester pops head result
- `busy`  out  1  FSM not in IDLE or job queue non-empty
- `fact_a`  out  2  accelerator register address
- `fact_we`  out  1  accelerator write enable
- `fact_wd`  out  4  accelerator write data
- `fact_rd`  in  32  accelerator read data (combinational on `fact_a`)

## Operation
- Accelerator map: 0 = n (write wd[3:0]), 1 = go (write wd[0]=1), 2 = status (rd[0]=done, rd[1]=err), 3 = result. Go write clears done.
- Job accepted on edge where `job_valid & job_ready`; result popped where `res_valid & res_ready`.
- Exactly one job in flight. FSM:
  - IDLE: if job queue non-empty and result queue not full → pop job, latch n → WR_N. Else stay.
  - WR_N: `fact_a`=0, `fact_we`=1, `fact_wd`=n → WR_GO.
  - WR_GO: `fact_a`=1, `fact_we`=1, `fact_wd`=4'd1 → POLL.
  - POLL: `fact_a`=2, `fact_we`=0; if `fact_rd[0]` → latch `fact_rd[1]` as err → RD_RES; else stay.
  - RD_RES: `fact_a`=3, `fact_we`=0; push {`fact_rd`, err, timeout=0} into result queue → IDLE.
- Outside WR_N/WR_GO: `fact_we`=0, `fact_wd`=0. IDLE drives `fact_a`=2.
- Result order equals job acceptance order.
- Job queue full: `job_ready`=0; push+pop same cycle on full queue → push refused (ready depends on full only).
- Result queue: simultaneous push and pop permitted at any occupancy, including full.
- Pointer wrap: queues use log2(depth)+1-bit pointers; full/empty from MSB compare; no entry loss at wrap.

## Timing
- Reset: state IDLE, both queues empty, `job_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0, `res_timeout`=0, `busy`=0, `fact_a`=2, `fact_we`=0, `fact_wd`=0.
- Job accepted at edge 0 → IDLE pops at cycle 1 → WR_N cycle 2 → WR_GO cycle 3 → POLL from cycle 4.
- Done seen in POLL at cycle P → RD_RES at P+1 → `res_valid` high at P+2 (queue previously empty).
- Back-to-back jobs: next WR_N at earliest 2 cycles after RD_RES.
- `rst` mid-job: all state cleared next edge; queued jobs and results discarded; accelerator reset by the same `rst`.

## Configuration
- `FACT_SCHED_TIMEOUT_EN` defined: POLL counter counts from 0 on POLL entry; when count reaches `TIMEOUT`-1 without done → push {32'd0, err=1, timeout=1} → IDLE. Counter zeroed in every other state.
- Undefined: no counter; POLL waits indefinitely; `res_timeout` tied 0; `TIMEOUT` ignored.

## Structure
- `fact_sched_pkg`: state enum (IDLE, WR_N, WR_GO, POLL, RD_RES), register address constants `FACT_A_N`, `FACT_A_GO`, `FACT_A_STAT`, `FACT_A_RES`, status bit indices.
- Sub-module `fact_sched_fifo` (parameterised width/depth, sync FIFO with full/empty), instantiated twice: job (4 bits), result (34 bits).

## Test plan
- Single job n=5, accelerator model done 3 cycles after go → `res_data`=120, `res_err`=0; bus sequence WR_N(a=0,wd=5), WR_GO(a=1,wd=1), POLL, RD_RES(a=3) exact cycles.
- Push 6 jobs n=1..6 with `res_ready`=0, depths 4 → `job_ready` drops after 4 accepted plus in-flight; results 1,2,6,24 then stall until pops; all 6 delivered in order.
- Model flags err for n=13 → `res_err`=1 for that entry only, neighbours clean.
- Full result queue with simultaneous pop and RD_RES push → occupancy stays 4, no loss, order kept.
- Assert `rst` during POLL → next cycle `fact_we`=0, `res_valid`=0, `job_ready`=1, `busy`=0; fresh job completes correctly.
- With `FACT_SCHED_TIMEOUT_EN`, `TIMEOUT`=8, model never raises done → result {0, err=1, timeout=1} after 8 POLL cycles; next job proceeds normally.
